// File: rtl/ctrl_cmd_driver_pkg.sv
// Shared definitions for the DDR2 controller command driver:
// command encoding, driver FSM states, FIFO payload layout and beat helper.
package ctrl_cmd_driver_pkg;

    localparam int unsigned TXN_ADDR_W = 25;
    localparam int unsigned TXN_DATA_W = 16;
    localparam int unsigned BEAT_W     = 6;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_SCR  = 3'd1,
        CMD_SCW  = 3'd2,
        CMD_BLR  = 3'd3,
        CMD_BLW  = 3'd4,
        CMD_ATR  = 3'd5,
        CMD_ATW  = 3'd6,
        CMD_NOP7 = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_BLK_WR = 2'd2
    } drv_state_e;

    typedef struct packed {
        cmd_e                  cmd;
        logic [1:0]            sz;
        logic [2:0]            op;
        logic [TXN_ADDR_W-1:0] addr;
        logic [TXN_DATA_W-1:0] data;
    } txn_t;

    // Block-write length in data words: 8, 16, 24 or 32.
    function automatic logic [BEAT_W-1:0] sz_to_beats(input logic [1:0] sz);
        return BEAT_W'((32'(sz) + 32'd1) << 3);
    endfunction

endpackage

// File: rtl/ctrl_cmd_driver_cmd_fifo.sv
// Synchronous FIFO, power-of-two depth, head visible on rdata_o.
// Ports: push_i/wdata_i write side, pop_i/rdata_o read side,
//        full_o/empty_o/count_o registered occupancy status.
module cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/ctrl_cmd_driver.sv
// Command-bus driver: buffers transactions and issues them one per cycle to
// the DDR2 controller, then streams block-write words while it fetches.
// Ports: txn_* valid/ready intake, wr_* block-write data stream,
//        notfull/fetching controller flow control, cmd/sz/op/addr/din bus,
//        busy (work pending), underrun (sticky missing-data flag).
module ctrl_cmd_driver
    import ctrl_cmd_driver_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = TXN_ADDR_W,
    parameter int unsigned DATA_W     = TXN_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              txn_valid,
    output logic              txn_ready,
    input  logic [2:0]        txn_cmd,
    input  logic [1:0]        txn_sz,
    input  logic [2:0]        txn_op,
    input  logic [ADDR_W-1:0] txn_addr,
    input  logic [DATA_W-1:0] txn_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              notfull,
    input  logic              fetching,
    output logic [2:0]        cmd,
    output logic [1:0]        sz,
    output logic [2:0]        op,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TXN_W = $bits(txn_t);

    drv_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic              push_c, pop_c;
    txn_t              push_txn, head_txn;
    logic [TXN_W-1:0]  head_bits;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count, count_next;

    logic [2:0]        cmd_q, cmd_d;
    logic [1:0]        sz_q, sz_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic              txn_ready_q, txn_ready_d;
    logic              wr_ready_c;
    logic [DATA_W-1:0] blk_din_c;

    // NOP encodings complete the handshake but never enter the FIFO.
    assign push_c = txn_valid && txn_ready_q && !fifo_full &&
                    (txn_cmd != CMD_NOP) && (txn_cmd != CMD_NOP7);

    always_comb begin
        push_txn      = '0;
        push_txn.cmd  = cmd_e'(txn_cmd);
        push_txn.sz   = txn_sz;
        push_txn.op   = txn_op;
        push_txn.addr = TXN_ADDR_W'(txn_addr);
        push_txn.data = TXN_DATA_W'(txn_data);
    end

    cmd_fifo #(
        .WIDTH (TXN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (push_txn),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_txn   = txn_t'(head_bits);
    assign count_next = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
        end
    end

    // Next state and pop decision; the FIFO is never popped during BLK_WR.
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && notfull) begin
                    pop_c   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_q == CMD_BLW) begin
                    beats_d = sz_to_beats(sz_q);
                    state_d = ST_BLK_WR;
                end else if (!fifo_empty && notfull) begin
                    pop_c = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLK_WR: begin
                // Every fetch consumes a beat, even without data behind it.
                if (fetching) begin
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: bus values for the next cycle plus the data stream path.
    always_comb begin
        cmd_d       = '0;
        sz_d        = '0;
        op_d        = '0;
        addr_d      = '0;
        din_d       = '0;
        underrun_d  = underrun_q;
        wr_ready_c  = 1'b0;
        blk_din_c   = '0;
        if (pop_c) begin
            cmd_d  = head_txn.cmd;
            sz_d   = head_txn.sz;
            op_d   = head_txn.op;
            addr_d = ADDR_W'(head_txn.addr);
            if (head_txn.cmd inside {CMD_SCW, CMD_ATR, CMD_ATW})
                din_d = DATA_W'(head_txn.data);
        end
        if (state_q == ST_BLK_WR) begin
            wr_ready_c = fetching;
            if (fetching && wr_valid) blk_din_c = wr_data;
            if (fetching && !wr_valid) underrun_d = 1'b1;
        end
        busy_d      = (count_next != '0) || (state_d != ST_IDLE);
        txn_ready_d = (count_next != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            sz_q        <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            txn_ready_q <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            sz_q        <= sz_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
            txn_ready_q <= txn_ready_d;
        end
    end

    // Write words pass straight through so the controller samples the word
    // in the same cycle it asserts fetching; the source advances on wr_ready.
    assign wr_ready  = wr_ready_c;
    assign din       = (state_q == ST_BLK_WR) ? blk_din_c : din_q;
    assign cmd       = cmd_q;
    assign sz        = sz_q;
    assign op        = op_q;
    assign addr      = addr_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
    assign txn_ready = txn_ready_q;

endmodule

// File: tb/tb_ctrl_cmd_driver.sv
// Directed bench for ctrl_cmd_driver with hand-computed expectations.
module tb_ctrl_cmd_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        txn_valid;
    logic        txn_ready;
    logic [2:0]  txn_cmd;
    logic [1:0]  txn_sz;
    logic [2:0]  txn_op;
    logic [24:0] txn_addr;
    logic [15:0] txn_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        notfull;
    logic        fetching;
    logic [2:0]  cmd;
    logic [1:0]  sz;
    logic [2:0]  op;
    logic [24:0] addr;
    logic [15:0] din;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_cmd_driver #(
        .FIFO_DEPTH (4),
        .ADDR_W     (25),
        .DATA_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .txn_valid (txn_valid),
        .txn_ready (txn_ready),
        .txn_cmd   (txn_cmd),
        .txn_sz    (txn_sz),
        .txn_op    (txn_op),
        .txn_addr  (txn_addr),
        .txn_data  (txn_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .notfull   (notfull),
        .fetching  (fetching),
        .cmd       (cmd),
        .sz        (sz),
        .op        (op),
        .addr      (addr),
        .din       (din),
        .busy      (busy),
        .underrun  (underrun)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_txn(input logic v, input logic [2:0] c, input logic [1:0] s,
                           input logic [2:0] o, input logic [24:0] a, input logic [15:0] d);
        txn_valid = v;
        txn_cmd   = c;
        txn_sz    = s;
        txn_op    = o;
        txn_addr  = a;
        txn_data  = d;
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] c, input logic [1:0] s,
                           input logic [2:0] o, input logic [24:0] a, input logic [15:0] d);
        chk({tag, ".cmd"}, 64'(cmd), 64'(c));
        chk({tag, ".sz"}, 64'(sz), 64'(s));
        chk({tag, ".op"}, 64'(op), 64'(o));
        chk({tag, ".addr"}, 64'(addr), 64'(a));
        chk({tag, ".din"}, 64'(din), 64'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [15:0] exp_d;

        // Reset held with a transaction offered
        rst_n = 1'b0; notfull = 1'b1; fetching = 1'b0; wr_valid = 1'b0; wr_data = '0;
        set_txn(1'b1, 3'd2, 2'd0, 3'd0, 25'h00ABC, 16'h1234);
        repeat (3) nxt();
        chk_bus("rst_bus", 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        rst_n = 1'b1;
        nxt();
        chk("rel_txn_ready", 64'(txn_ready), 64'd1);
        chk("rel_cmd", 64'(cmd), 64'd0);
        nxt();
        chk("rel_cmd2", 64'(cmd), 64'd0);
        chk("rel_busy", 64'(busy), 64'd0);

        // Scalar read: accept in cycle N, on bus in N+2 for one cycle
        set_txn(1'b1, 3'd1, 2'd0, 3'd0, 25'h0012345, 16'h0);
        nxt();
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        chk("rd_n1_cmd", 64'(cmd), 64'd0);
        chk("rd_n1_busy", 64'(busy), 64'd1);
        nxt();
        chk_bus("rd_issue", 3'd1, 2'd0, 3'd0, 25'h0012345, 16'h0);
        nxt();
        chk("rd_after_cmd", 64'(cmd), 64'd0);
        chk("rd_after_busy", 64'(busy), 64'd0);

        // NOP encodings are accepted but dropped
        set_txn(1'b1, 3'd7, 2'd0, 3'd0, 25'h00005, 16'h0);
        nxt();
        set_txn(1'b1, 3'd0, 2'd0, 3'd0, 25'h00006, 16'h0);
        nxt();
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        chk("nop_busy", 64'(busy), 64'd0);
        nxt();
        chk("nop_cmd", 64'(cmd), 64'd0);
        chk("nop_busy2", 64'(busy), 64'd0);

        // fetching outside BLK_WR is ignored
        fetching = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF;
        #1;
        chk("idle_fetch_wr_ready", 64'(wr_ready), 64'd0);
        chk("idle_fetch_din", 64'(din), 64'd0);
        fetching = 1'b0; wr_valid = 1'b0;
        nxt();

        // Block write, sz=1 -> 16 words in bursts of 4 with 2-cycle gaps
        set_txn(1'b1, 3'd4, 2'd1, 3'd0, 25'h0040000, 16'h0);
        nxt();
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        nxt();
        chk_bus("blw_issue", 3'd4, 2'd1, 3'd0, 25'h0040000, 16'h0);
        nxt();
        chk("blw_cmd0", 64'(cmd), 64'd0);
        chk("blw_busy", 64'(busy), 64'd1);
        k = 0;
        for (int b = 0; b < 4; b++) begin
            for (int f = 0; f < 4; f++) begin
                fetching = 1'b1; wr_valid = 1'b1; wr_data = 16'(k);
                #1;
                chk("blw_din", 64'(din), 64'(k));
                chk("blw_wr_ready", 64'(wr_ready), 64'd1);
                nxt();
                k++;
            end
            for (int g = 0; g < 2; g++) begin
                fetching = 1'b0; wr_valid = 1'b0;
                #1;
                chk("blw_gap_wr_ready", 64'(wr_ready), 64'd0);
                chk("blw_gap_din", 64'(din), 64'd0);
                chk("blw_gap_cmd", 64'(cmd), 64'd0);
                if (b == 0 && g == 0) chk("blw_mid_busy", 64'(busy), 64'd1);
                nxt();
            end
        end
        chk("blw_end_busy", 64'(busy), 64'd0);
        chk("blw_end_underrun", 64'(underrun), 64'd0);

        // Backpressure: three writes queued behind notfull=0
        notfull = 1'b0;
        set_txn(1'b1, 3'd2, 2'd0, 3'd0, 25'h0000010, 16'hA1A1);
        nxt();
        set_txn(1'b1, 3'd2, 2'd0, 3'd0, 25'h0000020, 16'hA2A2);
        nxt();
        set_txn(1'b1, 3'd2, 2'd0, 3'd0, 25'h0000030, 16'hA3A3);
        nxt();
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        nxt();
        nxt();
        chk("bp_cmd", 64'(cmd), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        notfull = 1'b1;
        nxt();
        chk_bus("bp_w1", 3'd2, 2'd0, 3'd0, 25'h0000010, 16'hA1A1);
        nxt();
        chk_bus("bp_w2", 3'd2, 2'd0, 3'd0, 25'h0000020, 16'hA2A2);
        nxt();
        chk_bus("bp_w3", 3'd2, 2'd0, 3'd0, 25'h0000030, 16'hA3A3);
        nxt();
        chk("bp_done_cmd", 64'(cmd), 64'd0);
        chk("bp_done_busy", 64'(busy), 64'd0);

        // FIFO full: 5 offered while stalled, 5th held until space frees
        notfull = 1'b0;
        set_txn(1'b1, 3'd1, 2'd0, 3'd0, 25'h001AAAA, 16'h0);
        nxt();
        chk("full_rdy1", 64'(txn_ready), 64'd1);
        set_txn(1'b1, 3'd2, 2'd0, 3'd0, 25'h000BBBB, 16'hB0B0);
        nxt();
        chk("full_rdy2", 64'(txn_ready), 64'd1);
        set_txn(1'b1, 3'd5, 2'd0, 3'd3, 25'h000CCCC, 16'hC0C0);
        nxt();
        chk("full_rdy3", 64'(txn_ready), 64'd1);
        set_txn(1'b1, 3'd6, 2'd0, 3'd5, 25'h000DDDD, 16'hD0D0);
        nxt();
        chk("full_rdy4", 64'(txn_ready), 64'd0);
        set_txn(1'b1, 3'd3, 2'd2, 3'd0, 25'h000EEEE, 16'h0);
        nxt();
        chk("full_hold1", 64'(txn_ready), 64'd0);
        nxt();
        chk("full_hold2", 64'(txn_ready), 64'd0);
        chk("full_cmd", 64'(cmd), 64'd0);
        notfull = 1'b1;
        nxt();
        chk_bus("full_a", 3'd1, 2'd0, 3'd0, 25'h001AAAA, 16'h0);
        chk("full_rdy_free", 64'(txn_ready), 64'd1);
        nxt();
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        chk_bus("full_b", 3'd2, 2'd0, 3'd0, 25'h000BBBB, 16'hB0B0);
        nxt();
        chk_bus("full_c", 3'd5, 2'd0, 3'd3, 25'h000CCCC, 16'hC0C0);
        nxt();
        chk_bus("full_d", 3'd6, 2'd0, 3'd5, 25'h000DDDD, 16'hD0D0);
        nxt();
        chk_bus("full_e", 3'd3, 2'd2, 3'd0, 25'h000EEEE, 16'h0);
        nxt();
        chk("full_done_cmd", 64'(cmd), 64'd0);
        chk("full_done_busy", 64'(busy), 64'd0);

        // Underrun: sz=0 block write, data missing on beat 3
        set_txn(1'b1, 3'd4, 2'd0, 3'd0, 25'h0001000, 16'h0);
        nxt();
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        nxt();
        chk("ur_issue_cmd", 64'(cmd), 64'd4);
        nxt();
        for (int b = 0; b < 8; b++) begin
            fetching = 1'b1;
            wr_valid = (b != 2);
            wr_data  = 16'(16'h00A0 + b);
            exp_d    = (b == 2) ? 16'h0 : 16'(16'h00A0 + b);
            #1;
            chk("ur_din", 64'(din), 64'(exp_d));
            chk("ur_wr_ready", 64'(wr_ready), 64'd1);
            chk("ur_flag", 64'(underrun), (b >= 3) ? 64'd1 : 64'd0);
            nxt();
        end
        fetching = 1'b0; wr_valid = 1'b0;
        #1;
        chk("ur_end_busy", 64'(busy), 64'd0);
        chk("ur_sticky1", 64'(underrun), 64'd1);
        nxt();
        chk("ur_sticky2", 64'(underrun), 64'd1);

        // Reset in the middle of a block write, with a command still queued
        set_txn(1'b1, 3'd4, 2'd1, 3'd0, 25'h0002000, 16'h0);
        nxt();
        set_txn(1'b1, 3'd1, 2'd0, 3'd0, 25'h0003000, 16'h0);
        nxt();
        set_txn(1'b0, 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        chk("rb_issue_cmd", 64'(cmd), 64'd4);
        nxt();
        chk("rb_blk_cmd", 64'(cmd), 64'd0);
        chk("rb_underrun_kept", 64'(underrun), 64'd1);
        for (int b = 0; b < 4; b++) begin
            fetching = 1'b1; wr_valid = 1'b1; wr_data = 16'(16'h0050 + b);
            nxt();
        end
        fetching = 1'b1; wr_valid = 1'b1; wr_data = 16'h0055;
        #1;
        chk("rb_beat5_din", 64'(din), 64'h0055);
        rst_n = 1'b0;
        #1;
        chk_bus("rb_reset_bus", 3'd0, 2'd0, 3'd0, 25'h0, 16'h0);
        chk("rb_reset_wr_ready", 64'(wr_ready), 64'd0);
        chk("rb_reset_busy", 64'(busy), 64'd0);
        chk("rb_reset_underrun", 64'(underrun), 64'd0);
        nxt();
        fetching = 1'b0; wr_valid = 1'b0;
        rst_n = 1'b1;
        nxt();
        chk("rb_rel_ready", 64'(txn_ready), 64'd1);
        nxt();
        chk("rb_rel_cmd", 64'(cmd), 64'd0);
        chk("rb_rel_busy", 64'(busy), 64'd0);
        nxt();
        chk("rb_rel_cmd2", 64'(cmd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
